// File: rtl/toggle_pair_checker.sv
// rtl/toggle_pair_checker.sv - toggle/ordering checker for a q/a register pair; TOGGLE_PAIR_CHECKER_STICKY_EN holds FAULT until clr or en=0
module toggle_pair_checker #(
  parameter int SYNC_LEN = 4,
  parameter int CNT_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             q_in,
  input  logic             a_in,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] tog_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int RUN_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  // run never needs to hold SYNC_LEN itself: the last good check locks instead of incrementing
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_LEN - 1);

  state_t           st, st_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [CNT_W-1:0] tog_nxt;
  logic [ERR_W-1:0] err_nxt;

  logic       s_q, s_a, p_q;
  logic [1:0] smp;
  logic       vld, tog_ok, rel_ok, good;

  // sample stage: register both inputs, keep previous q, and count edges until two samples exist
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0;
      s_a <= 1'b0;
      p_q <= 1'b0;
      smp <= 2'd0;
    end else begin
      s_q <= q_in;
      s_a <= a_in;
      p_q <= s_q;
      if (!en)
        smp <= 2'd0;
      else if (smp != 2'd2)
        smp <= smp + 2'd1;
    end
  end

  assign vld    = (smp == 2'd2) & en;
  assign tog_ok = s_q ^ p_q;

  // ordering relation of a to q selected by mode, evaluated on the registered samples
  always_comb begin
    rel_ok = 1'b0;
    case (mode)
      2'd0: rel_ok = (s_a == s_q);
      2'd1: rel_ok = (s_a == ~s_q);
      2'd2: rel_ok = (s_a == p_q);
      2'd3: rel_ok = (s_a == ~p_q);
      default: rel_ok = 1'b0;
    endcase
  end

  assign good = tog_ok & rel_ok;

  // state and counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      run     <= '0;
      tog_cnt <= '0;
      err_cnt <= '0;
    end else begin
      st      <= st_nxt;
      run     <= run_nxt;
      tog_cnt <= tog_nxt;
      err_cnt <= err_nxt;
    end
  end

  // next state: clr beats en=0, which beats the normal FSM; a violation under clr is dropped
  always_comb begin
    st_nxt  = st;
    run_nxt = run;
    tog_nxt = tog_cnt;
    err_nxt = err_cnt;
    if (clr) begin
      tog_nxt = '0;
      err_nxt = '0;
      run_nxt = '0;
      st_nxt  = en ? SYNC : IDLE;
    end else if (!en) begin
      st_nxt  = IDLE;
      run_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          st_nxt  = SYNC;
          run_nxt = '0;
        end
        SYNC: begin
          if (vld) begin
            if (good) begin
              if (run == RUN_LAST) begin
                st_nxt  = LOCKED;
                run_nxt = '0;
              end else begin
                run_nxt = run + RUN_W'(1);
              end
            end else begin
              run_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (vld) begin
            if (good) begin
              if (tog_cnt != '1)
                tog_nxt = tog_cnt + CNT_W'(1);
            end else begin
              st_nxt = FAULT;
              if (err_cnt != '1)
                err_nxt = err_cnt + ERR_W'(1);
            end
          end
        end
        FAULT: begin
`ifdef TOGGLE_PAIR_CHECKER_STICKY_EN
          st_nxt = FAULT;
`else
          st_nxt  = SYNC;
          run_nxt = '0;
`endif
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  assign state  = st;
  assign locked = (st == LOCKED);
  assign fault  = (st == FAULT);

endmodule

// File: tb/tb_toggle_pair_checker.sv
// tb/tb_toggle_pair_checker.sv - randomized self-checking bench for toggle_pair_checker
module tb_toggle_pair_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        q_in = 1'b0;
  logic        a_in = 1'b0;
  logic        locked, fault;
  logic [1:0]  state;
  logic [15:0] tog_cnt;
  logic [1:0]  err_cnt;

  toggle_pair_checker #(.SYNC_LEN(4), .CNT_W(16), .ERR_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .q_in(q_in), .a_in(a_in), .locked(locked), .fault(fault),
    .state(state), .tog_cnt(tog_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: histories of what was seen at the last edges plus the spec's state rules
  int m_state, m_run, m_tog, m_err;
  bit e1, e2, sq1, sq2, sa1;
  localparam int SL = 4;
  localparam int TOGMAX = 65535;
  localparam int ERRMAX = 3;

  bit gq = 1'b0, gprev = 1'b0;

  task automatic model_reset();
    m_state = 0; m_run = 0; m_tog = 0; m_err = 0;
    e1 = 0; e2 = 0; sq1 = 0; sq2 = 0; sa1 = 0;
  endtask

  task automatic model_edge();
    bit vld, tog_ok, rel_ok, good;
    vld    = en && e1 && e2;
    tog_ok = (sq1 != sq2);
    case (mode)
      2'd0: rel_ok = (sa1 == sq1);
      2'd1: rel_ok = (sa1 != sq1);
      2'd2: rel_ok = (sa1 == sq2);
      default: rel_ok = (sa1 != sq2);
    endcase
    good = tog_ok && rel_ok;
    if (clr) begin
      m_tog = 0; m_err = 0; m_run = 0;
      m_state = en ? 1 : 0;
    end else if (!en) begin
      m_state = 0; m_run = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_run = 0; end
        1: if (vld) begin
             if (!good) m_run = 0;
             else if (m_run + 1 == SL) begin m_state = 2; m_run = 0; end
             else m_run = m_run + 1;
           end
        2: if (vld) begin
             if (good) begin
               if (m_tog < TOGMAX) m_tog = m_tog + 1;
             end else begin
               m_state = 3;
               if (m_err < ERRMAX) m_err = m_err + 1;
             end
           end
        default: begin
`ifndef TOGGLE_PAIR_CHECKER_STICKY_EN
          m_state = 1; m_run = 0;
`endif
        end
      endcase
    end
    sq2 = sq1; sq1 = q_in; sa1 = a_in;
    e2 = e1; e1 = en;
  endtask

  function automatic logic [21:0] exp_vec();
    return {m_state[1:0], m_state == 2, m_state == 3, m_tog[15:0], m_err[1:0]};
  endfunction

  task automatic step(input bit e, input bit c, input bit [1:0] m, input bit q, input bit a);
    en = e; clr = c; mode = m; q_in = q; a_in = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // gm picks how the generated a relates to q; hold_q skips one toggle; flip_a corrupts a
  task automatic gen_step(input bit e, input bit c, input bit [1:0] m, input bit [1:0] gm,
                          input bit hold_q, input bit flip_a);
    bit a;
    gprev = gq;
    if (!hold_q) gq = ~gq;
    case (gm)
      2'd0: a = gq;
      2'd1: a = ~gq;
      2'd2: a = gprev;
      default: a = ~gprev;
    endcase
    if (flip_a) a = ~a;
    step(e, c, m, gq, a);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({state, locked, fault, tog_cnt, err_cnt} !== 22'd0)
      $display("FAIL reset_held: got %h want %h", {state, locked, fault, tog_cnt, err_cnt}, 22'd0);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
      $display("FAIL reset_idle: got %h want %h", {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
    else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
      n_checks++;
      if ({state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
        $display("FAIL lock_edge%0d: got %h want %h", i, {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
      else n_pass++;
      if (i == 5) begin
        n_checks++;
        if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0", locked);
        else n_pass++;
      end
      if (i >= 6) begin
        n_checks++;
        if (locked !== 1'b1 || tog_cnt !== 16'(i - 6) || err_cnt !== 2'd0)
          $display("FAIL lock_count%0d: got locked=%b tog=%0d err=%0d want 1 %0d 0", i, locked, tog_cnt, err_cnt, i - 6);
        else n_pass++;
      end
    end
  endtask

  task automatic test_delayed_mode();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      gen_step(1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0);
      n_checks++;
      if ({state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
        $display("FAIL delay_edge%0d: got %h want %h", i, {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL delay_locked: got %b want 1", locked);
    else n_pass++;
    gen_step(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    n_checks++;
    if (fault !== 1'b1 || err_cnt !== 2'd1 || {state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
      $display("FAIL delay_modeswitch: got %h want %h (fault=1 err=1)", {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
    else n_pass++;
  endtask

  task automatic test_missed_toggle();
    do_reset();
    for (int i = 0; i < 8; i++) gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL miss_still_locked: got %b want 1", locked);
    else n_pass++;
    gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (fault !== 1'b1 || err_cnt !== 2'd1)
      $display("FAIL miss_fault: got fault=%b err=%0d want 1 1", fault, err_cnt);
    else n_pass++;
`ifdef TOGGLE_PAIR_CHECKER_STICKY_EN
    for (int i = 0; i < 3; i++) begin
      gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
      n_checks++;
      if (fault !== 1'b1 || err_cnt !== 2'd1 || {state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
        $display("FAIL miss_sticky%0d: got %h want %h", i, {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
      else n_pass++;
    end
    gen_step(1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (state !== 2'd1 || err_cnt !== 2'd0)
      $display("FAIL miss_sticky_clr: got state=%0d err=%0d want 1 0", state, err_cnt);
    else n_pass++;
`else
    gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (state !== 2'd1 || fault !== 1'b0)
      $display("FAIL miss_resync: got state=%0d fault=%b want 1 0", state, fault);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
      n_checks++;
      if ({state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
        $display("FAIL miss_relock%0d: got %h want %h", i, {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (locked !== 1'b1 || err_cnt !== 2'd1)
      $display("FAIL miss_relocked: got locked=%b err=%0d want 1 1", locked, err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 8; i++) gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    for (int f = 1; f <= 5; f++) begin
      gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
`ifdef TOGGLE_PAIR_CHECKER_STICKY_EN
      gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
      gen_step(1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
`endif
      for (int i = 0; i < 8; i++) begin
        gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
        n_checks++;
        if ({state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
          $display("FAIL sat_f%0d_c%0d: got %h want %h", f, i, {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
        else n_pass++;
      end
      n_checks++;
      if (err_cnt !== 2'((f < 3) ? f : 3))
        $display("FAIL sat_err%0d: got %0d want %0d", f, err_cnt, (f < 3) ? f : 3);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 8; i++) gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b1);
    gen_step(1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (state !== 2'd1 || err_cnt !== 2'd0 || tog_cnt !== 16'd0)
      $display("FAIL prio_clr: got state=%0d err=%0d tog=%0d want 1 0 0", state, err_cnt, tog_cnt);
    else n_pass++;
    for (int i = 0; i < 8; i++) gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    gen_step(1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (state !== 2'd0 || tog_cnt !== 16'd4 || {state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
      $display("FAIL prio_en_off: got %h want %h (state 0 tog 4)", {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) gen_step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({state, locked, fault, tog_cnt, err_cnt} !== 22'd0)
      $display("FAIL async_reset: got %h want %h", {state, locked, fault, tog_cnt, err_cnt}, 22'd0);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit [1:0] gm = 2'd1;
    bit [1:0] m = 2'd1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39, 0) == 0) begin
        gm = 2'($urandom_range(3, 0));
        m  = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0)) : gm;
      end
      gen_step($urandom_range(59, 0) != 0, $urandom_range(99, 0) == 0, m, gm,
               $urandom_range(24, 0) == 0, $urandom_range(29, 0) == 0);
      n_checks++;
      if ({state, locked, fault, tog_cnt, err_cnt} !== exp_vec())
        $display("FAIL random_step%0d: got %h want %h", i, {state, locked, fault, tog_cnt, err_cnt}, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_delayed_mode();
    test_missed_toggle();
    test_saturation();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/toggle_pair_checker.md
Name: toggle_pair_checker

Overview:
- Downstream consumer of a toggle-pair stage, i.e. a register pair driving q (free-running divide-by-2 toggle) and a (derived copy of q) from the same clock.
- Samples both signals and checks two things every cycle: q toggles, and a holds the selected ordering relation to q.
- Locks after a run of clean cycles, then flags and counts violations.
- Used as the on-chip checker for toggle/ordering syntax experiments and as a health monitor on divided clocks.

Parameters:
- SYNC_LEN, 4: consecutive good checks required to reach LOCKED; must be ≥1.
- CNT_W, 16: width of tog_cnt.
- ERR_W, 8: width of err_cnt.

Ports:
- clk  input  1  rising-edge clock, same domain as the observed stage.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  checker enable; low forces IDLE.
- clr  input  1  synchronous single-cycle clear of counters and fault.
- mode  input  2  expected relation of a to q (see Behaviour).
- q_in  input  1  observed toggle output.
- a_in  input  1  observed derived output.
- locked  output  1  high while state is LOCKED.
- fault  output  1  high while state is FAULT.
- state  output  2  IDLE=0, SYNC=1, LOCKED=2, FAULT=3.
- tog_cnt  output  CNT_W  good toggles counted in LOCKED; saturating.
- err_cnt  output  ERR_W  violations counted; saturating.

Behaviour:
- Reset (async, rst=1) clears all of the following to 0: s_q, s_a, p_q, smp, run, state=IDLE, locked, fault, tog_cnt, err_cnt. Reset mid-operation aborts immediately; no partial count survives.
- Sample stage, every edge:
  - s_q<=q_in, s_a<=a_in, p_q<=s_q.
  - smp (2-bit) clears when en=0; otherwise increments on each edge, saturating at 2.
  - vld = (smp==2) & en.
- Combinational check on registered samples:
  - tog_ok = s_q^p_q.
  - rel_ok by mode: 0 → s_a==s_q; 1 → s_a==~s_q; 2 → s_a==p_q; 3 → s_a==~p_q.
  - good = tog_ok & rel_ok.
- Latency: an input present before edge k is sampled at edge k, checked during cycle k, and reflected in state/counters at edge k+1.
- Priority per edge: rst > clr > en=0 > FSM.
- en=0: state→IDLE, run→0; counters hold.
- clr=1:
  - tog_cnt, err_cnt, run → 0.
  - state→SYNC if en=1, else IDLE.
  - clr takes precedence over a simultaneous violation, which is not counted.
- FSM:
  - IDLE: en=1 → SYNC, run=0.
  - SYNC, vld&good: run+1; when run+1==SYNC_LEN → LOCKED, run=0.
  - SYNC, vld&!good: run=0, stay in SYNC; not counted as an error.
  - SYNC, !vld: hold.
  - LOCKED, vld&good: tog_cnt+1, saturating at all-ones.
  - LOCKED, vld&!good: → FAULT, err_cnt+1, saturating; tog_cnt holds.
  - FAULT: exit rule depends on the optional feature.
- Output timing: locked, fault and state are decoded from the state register, so they are glitch-free and change only at edges.
- mode changes take effect on the next check. A mode change while LOCKED that breaks the relation produces a fault; this is the intended behaviour.
- Saturation: both counters stop at 2^W−1 and never wrap.
- Timeline with en rising before edge 1:
  - IDLE→SYNC at edge 1.
  - First vld check in cycle 2.
  - With a clean input, LOCKED asserts after edge 2+SYNC_LEN (edge 6 by default).

Optional Feature:
- Macro: TOGGLE_PAIR_CHECKER_STICKY_EN.
- Defined: FAULT is held until clr=1 or en=0, and further violations are not counted while held.
- Undefined: FAULT lasts exactly one cycle, then → SYNC with run=0 and relocking is automatic. Each LOCKED→FAULT transition counts once.
- Port list is identical in both builds.

Test Plan:
- Lock: rst, en=1, mode=1, q_in toggling, a_in=~q_in → locked=1 after edge 6, tog_cnt increments 1 per cycle, err_cnt=0.
- Delayed mode: mode=2, a_in=q_in delayed one clock → locks by edge 6. Then switch to mode=0 → fault=1 the next edge, err_cnt=1.
- Missed toggle: locked, hold q_in for one cycle → fault for 1 cycle then SYNC, relocked after SYNC_LEN clean checks, err_cnt=1. With the STICKY macro, fault stays high until clr, then SYNC with err_cnt=0.
- Saturation: ERR_W=2, inject 5 single-cycle faults (non-sticky) → err_cnt=3 and holds.
- Priority: assert clr in the same cycle as a violation → err_cnt=0, state=SYNC. en=0 mid-LOCKED → IDLE next edge, counters hold.
- Async reset: pulse rst between edges while LOCKED → all outputs 0 immediately, before the next clk edge.
